// File: rtl/fc_dllp_scheduler.sv
// fc_dllp_scheduler
//   Generates the InitFC / UpdateFC command stream for the receive-side credit
//   allocator. After link-up it runs InitFC rounds over the three credit types
//   (MWr=00, MRd=01, Cpl=10). Once the local round minimum is met and the
//   partner has finished its InitFC, it moves to ACTIVE. In ACTIVE it issues
//   UpdateFC round-robin on credit release or on periodic timer expiry. Every
//   command is gated by DLLP-TX readiness.
//
//   Optional feature macro: FC_COALESCE_EN
//     defined   : a type's release pulses are counted; COALESCE_CNT of them
//                 are needed before that type becomes pending.
//     undefined : each release pulse makes its type pending directly.
//
// Ports
//   clk                 single clock
//   rst                 asynchronous, active-high reset
//   link_up_i           DLL link up; low forces IDLE
//   remote_init_done_i  partner InitFC received for all types (level)
//   credit_release_i    per-type release pulse (bit0 MWr, bit1 MRd, bit2 Cpl)
//   dllp_ready_i        DLLP TX can take an FC DLLP this cycle
//   is_initFC_o         one-cycle InitFC command
//   is_updateFC_o       one-cycle UpdateFC command
//   type_credit_o       credit type of current command (0 when idle)
//   init_done_o         high while in ACTIVE
//   pending_o           per-type UpdateFC pending flags
module fc_dllp_scheduler #(
  parameter int UPDATE_PERIOD   = 1024,
  parameter int MIN_INIT_ROUNDS = 2,
  parameter int COALESCE_CNT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_up_i,
  input  logic       remote_init_done_i,
  input  logic [2:0] credit_release_i,
  input  logic       dllp_ready_i,
  output logic       is_initFC_o,
  output logic       is_updateFC_o,
  output logic [1:0] type_credit_o,
  output logic       init_done_o,
  output logic [2:0] pending_o
);

  localparam logic [15:0] TIMER_LAST = 16'(UPDATE_PERIOD - 1);
  localparam logic [3:0]  MIN_ROUNDS = 4'(MIN_INIT_ROUNDS);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, ACTIVE = 2'd2} state_t;

  state_t      state, next_state;
  logic [1:0]  type_idx, type_idx_nxt;
  logic [3:0]  round_cnt, round_cnt_nxt, round_inc;
  logic [15:0] timer, timer_nxt;
  logic [1:0]  rr_ptr, rr_ptr_nxt;
  logic [2:0]  pending, pending_nxt, set_mask, clr_mask;
  logic [1:0]  grant_idx;
  logic        init_launch, round_end, grant_ok, timer_wrap;
  logic        is_init_nxt, is_upd_nxt, init_done_nxt;
  logic [1:0]  type_nxt;
`ifdef FC_COALESCE_EN
  localparam logic [7:0] COAL_LAST = 8'(COALESCE_CNT);
  logic [2:0][7:0] rel_cnt, rel_cnt_nxt;
`endif

  // First set request at or after ptr, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic       found;
    logic [2:0] sum;
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, ptr} + 3'(i);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && req[sum[1:0]]) begin
        pick  = sum[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign round_inc   = (round_cnt == 4'd15) ? 4'd15 : round_cnt + 4'd1;
  assign init_launch = link_up_i && dllp_ready_i && (state == INIT);
  assign round_end   = init_launch && (type_idx == 2'd2);
  assign grant_ok    = link_up_i && dllp_ready_i && (state == ACTIVE) && (pending != 3'b000);
  assign grant_idx   = rr_pick(pending, rr_ptr);
  assign timer_wrap  = (state == ACTIVE) && (timer == TIMER_LAST);
  assign pending_o   = pending;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; link loss overrides everything.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (link_up_i) next_state = INIT;
        else           next_state = IDLE;
      end
      INIT: begin
        if (!link_up_i)                                                   next_state = IDLE;
        else if (round_end && round_inc >= MIN_ROUNDS && remote_init_done_i) next_state = ACTIVE;
        else                                                              next_state = INIT;
      end
      ACTIVE: begin
        if (!link_up_i) next_state = IDLE;
        else            next_state = ACTIVE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command outputs and datapath next values.
  always_comb begin
    type_idx_nxt  = type_idx;
    round_cnt_nxt = round_cnt;
    timer_nxt     = timer;
    rr_ptr_nxt    = rr_ptr;
    pending_nxt   = pending;
    set_mask      = 3'b000;
    clr_mask      = 3'b000;
    is_init_nxt   = 1'b0;
    is_upd_nxt    = 1'b0;
    type_nxt      = 2'd0;
    init_done_nxt = (next_state == ACTIVE);
`ifdef FC_COALESCE_EN
    rel_cnt_nxt   = rel_cnt;
`endif
    if (!link_up_i || state == IDLE) begin
      type_idx_nxt  = 2'd0;
      round_cnt_nxt = 4'd0;
      timer_nxt     = 16'd0;
      rr_ptr_nxt    = 2'd0;
      pending_nxt   = 3'b000;
`ifdef FC_COALESCE_EN
      rel_cnt_nxt   = '0;
`endif
    end else if (state == INIT) begin
      if (init_launch) begin
        is_init_nxt  = 1'b1;
        type_nxt     = type_idx;
        type_idx_nxt = (type_idx == 2'd2) ? 2'd0 : type_idx + 2'd1;
      end else begin
        type_idx_nxt = type_idx;
      end
      if (round_end) round_cnt_nxt = round_inc;
      else           round_cnt_nxt = round_cnt;
      // ACTIVE always starts from a clean timer, pending set and pointer.
      if (next_state == ACTIVE) begin
        timer_nxt   = 16'd0;
        pending_nxt = 3'b000;
        rr_ptr_nxt  = 2'd0;
`ifdef FC_COALESCE_EN
        rel_cnt_nxt = '0;
`endif
      end else begin
        timer_nxt = timer;
      end
    end else begin
      timer_nxt = timer_wrap ? 16'd0 : timer + 16'd1;
`ifdef FC_COALESCE_EN
      if (timer_wrap) begin
        set_mask    = 3'b111;
        rel_cnt_nxt = '0;
      end else begin
        for (int t = 0; t < 3; t++) begin
          if (credit_release_i[t]) begin
            if (rel_cnt[t] + 8'd1 == COAL_LAST) begin
              set_mask[t]    = 1'b1;
              rel_cnt_nxt[t] = 8'd0;
            end else begin
              rel_cnt_nxt[t] = rel_cnt[t] + 8'd1;
            end
          end else begin
            rel_cnt_nxt[t] = rel_cnt[t];
          end
        end
      end
`else
      set_mask = credit_release_i | {3{timer_wrap}};
`endif
      if (grant_ok) begin
        is_upd_nxt = 1'b1;
        type_nxt   = grant_idx;
        clr_mask   = 3'b001 << grant_idx;
        rr_ptr_nxt = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end else begin
        rr_ptr_nxt = rr_ptr;
      end
      // A set arriving in the grant cycle survives the clear.
      pending_nxt = (pending & ~clr_mask) | set_mask;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_idx      <= 2'd0;
      round_cnt     <= 4'd0;
      timer         <= 16'd0;
      rr_ptr        <= 2'd0;
      pending       <= 3'b000;
      is_initFC_o   <= 1'b0;
      is_updateFC_o <= 1'b0;
      type_credit_o <= 2'd0;
      init_done_o   <= 1'b0;
`ifdef FC_COALESCE_EN
      rel_cnt       <= '0;
`endif
    end else begin
      type_idx      <= type_idx_nxt;
      round_cnt     <= round_cnt_nxt;
      timer         <= timer_nxt;
      rr_ptr        <= rr_ptr_nxt;
      pending       <= pending_nxt;
      is_initFC_o   <= is_init_nxt;
      is_updateFC_o <= is_upd_nxt;
      type_credit_o <= type_nxt;
      init_done_o   <= init_done_nxt;
`ifdef FC_COALESCE_EN
      rel_cnt       <= rel_cnt_nxt;
`endif
    end
  end

endmodule
